// File: rtl/pos_scan_pkg.sv
// Shared types and default constants for the board-position scan selector.
package pos_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NUM_POS_DEF  = 9;
    localparam int unsigned TICK_DIV_DEF = 4;

endpackage

// File: rtl/pos_next_free.sv
// Combinational wrap-around search: first eligible index at or after start_idx.
module pos_next_free #(
    parameter int unsigned N = 9,
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] start_idx,
    input  logic [N-1:0] eligible,
    output logic [W-1:0] index,
    output logic         found
);

    int unsigned cand;
    logic [W-1:0] cand_idx;

    always_comb begin
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(start_idx) + k;
            if (cand >= N) cand = cand - N;
            cand_idx = W'(cand);
            if (!found && eligible[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/pos_scan_select.sv
// Cursor scans board positions on a divided tick until select confirms one.
// Optional macro POS_SKIP_OCCUPIED_EN makes the cursor skip occupied positions.
module pos_scan_select
    import pos_scan_pkg::*;
#(
    parameter int unsigned NUM_POS  = NUM_POS_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       select,
    input  logic [NUM_POS-1:0]         occupied,
    output logic [$clog2(NUM_POS)-1:0] pos,
    output logic                       Ready,
    output logic                       busy,
    output logic                       none_free
);

    localparam int unsigned POS_W = $clog2(NUM_POS);
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [NUM_POS-1:0] eligible;
    logic [POS_W-1:0]   search_from;
    logic [POS_W-1:0]   next_idx;
    logic               next_found;
    logic               tick_tc;
    logic               select_ok;

`ifdef POS_SKIP_OCCUPIED_EN
    assign eligible = ~occupied;
`else
    logic unused_occupied;
    assign unused_occupied = ^occupied;
    assign eligible        = '1;
`endif

    assign tick_tc   = (div == DIV_W'(TICK_DIV - 1));
    // Live check: a position taken under the cursor blocks select until it moves.
    assign select_ok = eligible[pos];

    always_comb begin
        search_from = '0;
        if (state == SCAN) begin
            search_from = (pos == POS_W'(NUM_POS - 1)) ? '0 : pos + POS_W'(1);
        end
    end

    pos_next_free #(
        .N (NUM_POS),
        .W (POS_W)
    ) u_next (
        .start_idx (search_from),
        .eligible  (eligible),
        .index     (next_idx),
        .found     (next_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pos       <= '0;
            div       <= '0;
            Ready     <= 1'b0;
            busy      <= 1'b0;
            none_free <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Ready <= 1'b0;
                    if (start) begin
                        div <= '0;
                        if (next_found) begin
                            state     <= SCAN;
                            busy      <= 1'b1;
                            pos       <= next_idx;
                            none_free <= 1'b0;
                        end else begin
                            pos       <= '0;
                            none_free <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (select && select_ok) begin
                        state <= DONE;
                        Ready <= 1'b1;
                        busy  <= 1'b0;
                    end else if (tick_tc) begin
                        div <= '0;
                        if (next_found) begin
                            pos <= next_idx;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            pos       <= '0;
                            none_free <= 1'b1;
                        end
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pos_scan_select.sv
// Directed bench for pos_scan_select at default parameters; skip-occupied cases under POS_SKIP_OCCUPIED_EN.
module tb_pos_scan_select;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       select;
    logic [8:0] occupied;
    logic [3:0] pos;
    logic       ready;
    logic       busy;
    logic       none_free;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pos_scan_select #(
        .NUM_POS  (9),
        .TICK_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .select    (select),
        .occupied  (occupied),
        .pos       (pos),
        .Ready     (ready),
        .busy      (busy),
        .none_free (none_free)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        select   = 1'b0;
        occupied = '0;
        tick(2);
        check("rst_pos", pos, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_none_free", none_free, 0);

        reset = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_pos", pos, 0);
        // Scan sequence: pos advances every 4 cycles, wraps after 36
        for (int unsigned c = 1; c <= 36; c++) begin
            tick(1);
            check($sformatf("scan_pos_c%0d", c), pos, (c / 4) % 9);
        end
        check("scan_busy", busy, 1);
        check("scan_ready_low", ready, 0);

        // Select at pos 5 (c=57 since start, div mid-count)
        tick(21);
        check("pre_sel_pos5", pos, 5);
        select = 1'b1;
        tick(1);
        select = 1'b0;
        check("sel5_ready", ready, 1);
        check("sel5_pos", pos, 5);
        check("sel5_busy", busy, 0);
        tick(1);
        check("sel5_ready_pulse", ready, 0);
        check("sel5_idle_busy", busy, 0);
        check("sel5_idle_pos", pos, 5);
        tick(2);
        check("sel5_hold_pos", pos, 5);
        select = 1'b1;
        tick(1);
        select = 1'b0;
        check("idle_select_ready", ready, 0);
        check("idle_select_busy", busy, 0);

        // Select coincident with terminal count at pos 8; start held through DONE
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("r2_pos", pos, 0);
        tick(35);
        check("r2_pre_pos8", pos, 8);
        select = 1'b1;
        start  = 1'b1;
        tick(1);
        select = 1'b0;
        check("tc_sel_ready", ready, 1);
        check("tc_sel_pos", pos, 8);
        tick(1);
        start = 1'b0;
        check("done_start_busy", busy, 0);
        check("done_ready_low", ready, 0);
        check("done_pos8", pos, 8);
        tick(1);
        check("after_done_busy", busy, 0);
        check("after_done_pos", pos, 8);

        // Async reset mid-scan at pos 3
`ifndef POS_SKIP_OCCUPIED_EN
        occupied = 9'h1FF;
`endif
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(12);
        check("r3_pos3", pos, 3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pos", pos, 0);
        check("async_rst_ready", ready, 0);
        check("async_rst_busy", busy, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("r4_busy", busy, 1);
        check("r4_pos", pos, 0);
        check("r4_none_free", none_free, 0);
        tick(4);
        check("r4_pos_adv", pos, 1);
        reset = 1'b1;
        tick(1);
        reset    = 1'b0;
        occupied = '0;
        tick(1);

`ifdef POS_SKIP_OCCUPIED_EN
        begin
            int unsigned exp_seq [7] = '{0, 3, 5, 6, 7, 8, 0};
            occupied = 9'b000010110;
            start = 1'b1;
            tick(1);
            start = 1'b0;
            check("skip_pos_0", pos, exp_seq[0]);
            for (int unsigned i = 1; i < 7; i++) begin
                tick(4);
                check($sformatf("skip_pos_%0d", i), pos, exp_seq[i]);
            end
            // Position under cursor becomes occupied: select must be ignored
            occupied = 9'b000010111;
            select = 1'b1;
            tick(1);
            select = 1'b0;
            check("occ_sel_ready", ready, 0);
            check("occ_sel_busy", busy, 1);
            // All occupied mid-scan: abort at next terminal count
            occupied = 9'h1FF;
            tick(3);
            check("abort_busy", busy, 0);
            check("abort_none_free", none_free, 1);
            check("abort_pos", pos, 0);
            // All occupied at start
            tick(1);
            start = 1'b1;
            tick(1);
            start = 1'b0;
            check("full_none_free", none_free, 1);
            check("full_ready", ready, 0);
            check("full_busy", busy, 0);
            check("full_pos", pos, 0);
            occupied = '0;
            start = 1'b1;
            tick(1);
            start = 1'b0;
            check("free_again_none_free", none_free, 0);
            check("free_again_busy", busy, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pos_scan_select.md
POS_SCAN_SELECT -- requirements
Module: pos_scan_select

Interface
REQ-001 SHALL provide parameter NUM_POS, default 9, number of selectable board positions (2..16).
REQ-002 SHALL provide parameter TICK_DIV, default 4, clock cycles per cursor advance (>=1).
REQ-003 SHALL derive localparam POS_W = $clog2(NUM_POS), the cursor width.
REQ-004 SHALL provide clk  input  1  single system clock, rising-edge.
REQ-005 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide start  input  1  begin a selection round.
REQ-007 SHALL provide select  input  1  confirm the current cursor position.
REQ-008 SHALL provide occupied  input  NUM_POS  per-position taken flags, bit i = position i.
REQ-009 SHALL provide pos  output  POS_W  cursor / chosen position.
REQ-010 SHALL provide Ready  output  1  one-cycle pulse: pos is the chosen position.
REQ-011 SHALL provide busy  output  1  high while in SCAN.
REQ-012 SHALL provide none_free  output  1  last round aborted because no position was eligible.

Function
REQ-013 SHALL implement states IDLE, SCAN, DONE.
REQ-014 IDLE: start sampled high -> SCAN next cycle, pos = first eligible position searched from 0, divider cleared, none_free cleared.
REQ-015 SCAN: divider counts 0..TICK_DIV-1; at terminal count pos moves to next eligible position after pos, wrapping NUM_POS-1 -> 0.
REQ-016 SCAN: select sampled high -> DONE next cycle with pos frozen; Ready high for exactly that one cycle.
REQ-017 select and divider terminal count on the same edge: select wins, pos not advanced.
REQ-018 DONE -> IDLE unconditionally after one cycle; pos holds the chosen value in IDLE until next start.
REQ-019 start while in SCAN or DONE SHALL be ignored; select outside SCAN SHALL be ignored.
REQ-020 Ready SHALL never be high for two consecutive cycles.
REQ-021 busy SHALL equal (state == SCAN).
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 reset high at any time, including mid-SCAN or in DONE, SHALL force IDLE, pos=0, divider=0, Ready=0, busy=0, none_free=0 asynchronously.
REQ-024 First start after reset release SHALL behave as REQ-014.

Configuration
REQ-025 Macro POS_SKIP_OCCUPIED_EN defined: "eligible" = occupied[i]==0; cursor skips taken positions.
REQ-026 With macro: if no eligible position exists at start, SHALL return to IDLE next cycle with none_free=1, Ready=0, pos=0.
REQ-027 With macro: if occupied[pos] rises during SCAN, select SHALL be ignored until the cursor moves; if all positions become occupied mid-SCAN, abort per REQ-026 at next terminal count.
REQ-028 Macro undefined: occupied ignored, every position eligible, none_free tied 0.

Structure
REQ-029 Package pos_scan_pkg SHALL hold the state enum typedef and default constants (NUM_POS_DEF=9, TICK_DIV_DEF=4).
REQ-030 Sub-module pos_next_free SHALL hold the combinational wrap-around next-eligible search (inputs: start index, eligible mask; outputs: index, found).

Verification
REQ-031 Defaults, no macro: start, hold select=0 -> pos sequence 0,1,...,8 changing every 4 cycles, wraps to 0 after 36 cycles in SCAN.
REQ-032 select sampled while pos=5 -> Ready=1 one cycle later for one cycle, pos=5 held, state IDLE next cycle, busy=0.
REQ-033 select on the same edge as terminal count with pos=8 -> pos stays 8, Ready pulses, no wrap to 0.
REQ-034 reset asserted mid-SCAN at pos=3 -> pos=0, Ready=0, busy=0 immediately, IDLE; new start -> pos=0.
REQ-035 POS_SKIP_OCCUPIED_EN, occupied=9'b000010110, start -> pos 0,3,5,6,7,8,0 per advance.
REQ-036 POS_SKIP_OCCUPIED_EN, occupied=9'h1FF, start -> none_free=1 next cycle, Ready=0, busy=0, pos=0.
